// File: rtl/alu_cmd_sequencer.sv
// Purpose: collects A, B and opcode bytes from a serial receiver, runs them through an external ALU and returns the result byte.
// Latency: opcode byte accepted at cycle N -> o_tx_start at cycle N+3 when the transmitter is ready.
// Backpressure: holds the result in SEND until i_tx_ready; bytes arriving in EXEC/SEND are dropped and flagged on o_overrun.
module alu_cmd_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_error,
    output logic               o_overrun
);

    // Idle counter only needs to reach TIMEOUT_CYCLES-1: the cycle that would
    // make it TIMEOUT_CYCLES is the one that fires the timeout.
    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    // Opcode bytes compared at full byte width so any set bit above the
    // opcode field makes the byte invalid.
    localparam logic [NB_DATA-1:0] OP_ADD = NB_DATA'(32);
    localparam logic [NB_DATA-1:0] OP_SUB = NB_DATA'(34);
    localparam logic [NB_DATA-1:0] OP_AND = NB_DATA'(36);
    localparam logic [NB_DATA-1:0] OP_OR  = NB_DATA'(37);
    localparam logic [NB_DATA-1:0] OP_XOR = NB_DATA'(38);
    localparam logic [NB_DATA-1:0] OP_SRA = NB_DATA'(3);
    localparam logic [NB_DATA-1:0] OP_SRL = NB_DATA'(2);
    localparam logic [NB_DATA-1:0] OP_NOR = NB_DATA'(39);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND
    } state_t;

    state_t             state_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic [NB_CNT-1:0]  cnt_d;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] result_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               error_q;
    logic               overrun_q;
    logic               op_ok;
    logic               timeout_hit;

    assign cnt_d       = cnt_q + NB_CNT'(1);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Decode whether the incoming byte is one of the supported opcodes.
    always_comb begin
        op_ok = 1'b0;
        case (i_rx_data)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    // Command FSM with registered operands, result and status strobes.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (i_rx_valid) begin
                        a_q     <= i_rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_valid) begin
                        b_q     <= i_rx_data;
                        cnt_q   <= '0;
                        state_q <= WAIT_OP;
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_valid) begin
                        cnt_q <= '0;
                        if (op_ok) begin
                            op_q    <= i_rx_data[NB_OP-1:0];
                            state_q <= EXEC;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                EXEC: begin
                    // Operands have been stable on the ALU for this whole cycle.
                    result_q <= i_alu_result;
                    state_q  <= SEND;
                    if (i_rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (i_rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (i_tx_ready) begin
                        tx_data_q  <= result_q;
                        tx_start_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_op   = op_q;
    assign o_busy     = (state_q != IDLE);
    assign o_error    = error_q;
    assign o_overrun  = overrun_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result/byte width.
REQ-002 Parameter NB_OP, default 6, ALU opcode width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, maximum idle cycles allowed between bytes of one command.
REQ-004 i_clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-low reset.
REQ-006 i_rx_data  input  NB_DATA  received byte; valid only while i_rx_valid=1.
REQ-007 i_rx_valid  input  1  one-cycle strobe, one byte per strobe.
REQ-008 i_tx_ready  input  1  transmitter idle, can accept a byte.
REQ-009 o_tx_data  output  NB_DATA  result byte to transmitter.
REQ-010 o_tx_start  output  1  one-cycle strobe launching o_tx_data.
REQ-011 o_alu_a, o_alu_b  output  NB_DATA each  ALU operands.
REQ-012 o_alu_op  output  NB_OP  ALU opcode.
REQ-013 i_alu_result  input  NB_DATA  combinational ALU result.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_error  output  1  one-cycle strobe on invalid opcode or timeout.
REQ-016 o_overrun  output  1  one-cycle strobe when a byte is dropped.

Function
REQ-017 FSM states SHALL be: IDLE, WAIT_B, WAIT_OP, EXEC, SEND.
REQ-018 IDLE + i_rx_valid: i_rx_data -> A register, next state WAIT_B.
REQ-019 WAIT_B + i_rx_valid: i_rx_data -> B register, next state WAIT_OP.
REQ-020 WAIT_OP + i_rx_valid with a valid opcode: i_rx_data[NB_OP-1:0] -> op register, next state EXEC.
REQ-021 Valid opcodes SHALL be exactly 32 ADD, 34 SUB, 36 AND, 37 OR, 38 XOR, 3 SRA, 2 SRL, 39 NOR; byte bits above NB_OP-1 must be zero.
REQ-022 Invalid opcode byte: o_error=1 on the next cycle; op register unchanged; next state IDLE; no transmission.
REQ-023 EXEC lasts exactly one cycle; i_alu_result is captured into the result register at its end; next state SEND.
REQ-024 SEND + i_tx_ready=1: next cycle o_tx_start=1 for one cycle, o_tx_data=captured result, state IDLE.
REQ-025 SEND + i_tx_ready=0: remain in SEND indefinitely, o_tx_start=0; no timeout applies in SEND.
REQ-026 Latency: op byte strobe at cycle N -> o_tx_start at cycle N+3 when i_tx_ready is held high.
REQ-027 o_alu_a, o_alu_b, o_alu_op are driven directly from the A/B/op registers and hold until overwritten.
REQ-028 o_tx_data holds its value after the strobe until the next result is sent.
REQ-029 i_rx_valid in EXEC or SEND: byte discarded, o_overrun=1 on the next cycle, state unaffected.
REQ-030 Timeout counter clears on every accepted byte and counts each cycle spent in WAIT_B or WAIT_OP without i_rx_valid.
REQ-031 Counter reaching TIMEOUT_CYCLES: o_error=1 on the next cycle, state IDLE, A/B/op registers unchanged.
REQ-032 i_rx_valid in the same cycle the counter reaches TIMEOUT_CYCLES: the byte SHALL be accepted; no timeout.
REQ-033 o_error and o_overrun never remain high for two consecutive cycles from a single event.

Reset
REQ-034 i_reset=0 at a clock edge: state IDLE; timeout counter 0; A, B, op, and result registers 0.
REQ-035 Reset values: o_tx_data=0, o_tx_start=0, o_busy=0, o_error=0, o_overrun=0.
REQ-036 Reset SHALL take priority over every other input in any state, including mid-command and in SEND; a partial command is discarded.

Verification
REQ-037 Bytes 0x05, 0x03, 0x20, i_alu_result modelled, i_tx_ready=1 -> o_alu_op=32, one o_tx_start strobe with o_tx_data=0x08, 3 cycles after the op byte.
REQ-038 Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE; bytes 0x80, 0x02, 0x03 -> o_tx_data=0xE0; bytes 0x0F, 0xF0, 0x27 -> o_tx_data=0x00.
REQ-039 Bytes 0x01, 0x02, 0x15 -> o_error strobe, no o_tx_start; a following 0x01, 0x01, 0x20 -> o_tx_data=0x02.
REQ-040 Byte 0x07, then no byte for TIMEOUT_CYCLES cycles -> o_error strobe, o_busy=0; a byte sent at exactly the limit cycle is accepted instead.
REQ-041 i_tx_ready=0 for 50 cycles in SEND, with an extra rx byte injected -> o_overrun strobe, o_busy=1 throughout; raise i_tx_ready -> single strobe with the original result.
REQ-042 i_reset=0 after bytes A and B -> all outputs 0, state IDLE; a fresh 3-byte command then completes normally.
